// File: rtl/uart_rx_if.sv
// CPU-side register bus of the uart_rx peripheral: address, strobes, write data,
// combinational read data and the access-accepted flag.
interface uart_rx_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] read_data;
    logic        rx_valid;

    modport master (
        output addr, write_data, write_enable, read_enable,
        input  read_data, rx_valid
    );

    modport slave (
        input  addr, write_data, write_enable, read_enable,
        output read_data, rx_valid
    );
endinterface

// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: 8N1 deserialiser, receive FIFO, RXDATA/STATUS registers.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus,
    input  logic      rx,
    output logic      rx_interrupt
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    function automatic logic [3:0] sat_occ(input logic [AW:0] c);
        int v;
        v = int'(c);
        if (v > 15) return 4'd15;
        return 4'(v);
    endfunction

    logic          rx_p0, rx_s;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    shift, shift_nx;
    logic          push, set_fe, set_pe;
    logic          par_bad, par_bad_nx;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic          empty, full, pop, do_push, clr;
    logic [1:0]    sel;
    logic          overrun, framing_err, parity_err;
    logic [31:0]   rdata;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_nx     = bit_idx;
        shift_nx   = shift;
        par_bad_nx = par_bad;
        push       = 1'b0;
        set_fe     = 1'b0;
        set_pe     = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_nx = START;
                cnt_nx   = '0;
            end
            START: if (cnt == HALF_BIT) begin
                cnt_nx   = '0;
                bit_nx   = '0;
                state_nx = rx_s ? IDLE : DATA;
            end else cnt_nx = cnt + 1'b1;
            DATA: if (cnt == FULL_BIT) begin
                cnt_nx   = '0;
                shift_nx = {rx_s, shift[7:1]};
                bit_nx   = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_idx == 3'd7) state_nx = PARITY;
`else
                if (bit_idx == 3'd7) state_nx = STOP;
`endif
            end else cnt_nx = cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt == FULL_BIT) begin
                cnt_nx     = '0;
                par_bad_nx = rx_s ^ (^shift);
                state_nx   = STOP;
            end else cnt_nx = cnt + 1'b1;
`endif
            STOP: if (cnt == FULL_BIT) begin
                cnt_nx = '0;
                if (rx_s) begin
                    set_pe   = par_bad;
                    push     = !par_bad;
                    state_nx = IDLE;
                end else begin
                    set_fe   = 1'b1;
                    state_nx = WAIT_HIGH;
                end
            end else cnt_nx = cnt + 1'b1;
            WAIT_HIGH: if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bad <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
            par_bad <= par_bad_nx;
        end
    end

    assign sel     = bus.addr[3:2];
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign pop     = bus.read_enable && (sel == 2'd0) && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || pop);
    assign clr     = bus.write_enable && (sel == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            overrun     <= (push && full && !pop) | (overrun & ~(clr & bus.write_data[2]));
            framing_err <= set_fe | (framing_err & ~(clr & bus.write_data[3]));
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= set_pe | (parity_err & ~(clr & bus.write_data[4]));
    end
    logic unused_bits;
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.write_data[31:5], bus.write_data[1:0]};
`else
    assign parity_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.write_data[31:4],
                           bus.write_data[1:0], set_pe, par_bad_nx};
`endif

    always_comb begin
        rdata = '0;
        case (sel)
            2'd0: if (!empty) rdata = {24'b0, mem[rd_ptr[AW-1:0]]};
            2'd1: rdata = {20'b0, sat_occ(count), 3'b0,
                           parity_err, framing_err, overrun, full, !empty};
            default: rdata = '0;
        endcase
    end

    assign bus.read_data = rdata;
    assign bus.rx_valid  = bus.read_enable | bus.write_enable;
    assign rx_interrupt  = !empty;
endmodule
